// File: rtl/pcpi_pkg.sv
// rtl/pcpi_pkg.sv - shared PCPI types, issuer state encoding and defaults
package pcpi_pkg;

  localparam int PCPI_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } issuer_state_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } pcpi_req_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
    logic        illegal;
  } pcpi_rsp_t;

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// rtl/pcpi_timeout_ctr.sv - no-claim watchdog: load, reload on busy, decrement, expire
module pcpi_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic load_i,
  input  logic run_i,
  input  logic busy_i,
  input  logic ready_i,
  output logic expire_o
);

  localparam logic [7:0] LOAD_VAL = 8'(TIMEOUT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       dec;

  // Busy means a co-processor claimed the instruction, so the window restarts.
  always_comb begin
    cnt_d = cnt_q;
    dec   = run_i & ~busy_i & ~ready_i;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (run_i && busy_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready in the expiry cycle suppresses expiry through dec.
  assign expire_o = dec & (cnt_q == 8'd1);

endmodule

// File: rtl/pcpi_issuer.sv
// rtl/pcpi_issuer.sv - core-side PCPI initiator with timeout-to-illegal
module pcpi_issuer
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT = PCPI_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_insn,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_wr,
  output logic [31:0]      rsp_rd,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  input  logic             pcpi_busy,
  input  logic             pcpi_ready
);

  issuer_state_e    state_q, state_d;
  pcpi_req_t        req_q, req_d;
  pcpi_rsp_t        rsp_q, rsp_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             tmo_load;
  logic             tmo_expire;

  pcpi_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .resetn   (resetn),
    .load_i   (tmo_load),
    .run_i    (state_q == ST_ISSUE),
    .busy_i   (pcpi_busy),
    .ready_i  (pcpi_ready),
    .expire_o (tmo_expire)
  );

  // Next-state and datapath capture; handshake outputs decode from state only.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rsp_d    = rsp_q;
    cyc_d    = cyc_q;
    tmo_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.insn = req_insn;
          req_d.rs1  = req_rs1;
          req_d.rs2  = req_rs2;
          cyc_d      = '0;
          tmo_load   = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cyc_q != '1) begin
          cyc_d = cyc_q + CNT_W'(1);
        end
        if (pcpi_ready) begin
          rsp_d.wr      = pcpi_wr;
          rsp_d.rd      = pcpi_wr ? pcpi_rd : 32'd0;
          rsp_d.illegal = 1'b0;
          state_d       = ST_RESP;
        end else if (tmo_expire) begin
          rsp_d.wr      = 1'b0;
          rsp_d.rd      = 32'd0;
          rsp_d.illegal = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops pcpi_valid immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      cyc_q   <= cyc_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign pcpi_valid  = (state_q == ST_ISSUE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign pcpi_insn   = req_q.insn;
  assign pcpi_rs1    = req_q.rs1;
  assign pcpi_rs2    = req_q.rs2;
  assign rsp_wr      = rsp_q.wr;
  assign rsp_rd      = rsp_q.rd;
  assign rsp_illegal = rsp_q.illegal;
  assign rsp_cycles  = cyc_q;

endmodule
